// File: rtl/traffic_light_timed_ctrl.sv
// traffic_light_timed_ctrl: timed single-approach traffic light with green extension,
// latched car request and emergency pre-emption.
module traffic_light_timed_ctrl #(
  parameter int CNT_W         = 8,
  parameter int RED_MIN       = 4,
  parameter int GREEN_MIN     = 6,
  parameter int GREEN_EXT_MAX = 4,
  parameter int YELLOW_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_car,
  input  logic             i_emergency,
  output logic             o_red,
  output logic             o_yellow,
  output logic             o_green,
  output logic [1:0]       o_state,
  output logic             o_req,
  output logic [CNT_W-1:0] o_timer
);
  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;
  localparam logic [CNT_W-1:0] RED_LD = CNT_W'(RED_MIN - 1);
  localparam logic [CNT_W-1:0] GRN_LD = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YEL_LD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXT_MX = CNT_W'(GREEN_EXT_MAX);
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, ext_q, ext_d;
  logic             req_q, req_d;
  logic             t_zero;
  logic [CNT_W-1:0] t_dec;
  assign t_zero = timer_q == '0;
  assign t_dec  = t_zero ? '0 : timer_q - 1'b1;
  always_comb begin
    state_d = RED;
    timer_d = RED_LD;
    ext_d   = ext_q;
    req_d   = 1'b0;
    if (state_q == RED) begin
      if (t_zero && (req_q || i_car) && !i_emergency) begin
        state_d = GREEN;
        timer_d = GRN_LD;
        ext_d   = '0;
      end else begin
        timer_d = t_dec;
        req_d   = req_q | i_car;
      end
    end else if (state_q == GREEN) begin
      // emergency outranks any pending extension grant
      if (i_emergency || (t_zero && !(i_car && ext_q < EXT_MX))) begin
        state_d = YELLOW;
        timer_d = YEL_LD;
      end else begin
        state_d = GREEN;
        timer_d = t_dec;
        ext_d   = t_zero ? ext_q + 1'b1 : ext_q;
      end
    end else if (state_q == YELLOW) begin
      state_d = t_zero ? RED : YELLOW;
      timer_d = t_zero ? RED_LD : t_dec;
    end
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RED;
      timer_q <= RED_LD;
      ext_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ext_q   <= ext_d;
      req_q   <= req_d;
    end
  end
  assign o_green  = state_q == GREEN;
  assign o_yellow = state_q == YELLOW;
  assign o_red    = !(o_green || o_yellow);
  assign o_state  = state_q;
  assign o_req    = req_q;
  assign o_timer  = timer_q;
endmodule
